mem_arbiter: RTL and testbench

//  Shares one downstream memory port (L2 / physical memory) between the I-cache and
//  D-cache miss paths. Requests arrive at the L1 memory side, after MMIO decode.
//  An FSM grants one requester at a time and holds the grant until downstream resp.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two L1 miss paths, the arbiter and the downstream
// memory port. The arbiter uses the slave modport; the requester/memory side
// (cache controllers, or a bench) uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the I-cache and
// D-cache miss paths. One requester is granted at a time and keeps the grant
// until mem_resp; simultaneous requests from IDLE alternate round-robin.
// Optional feature macro ARB_PERF_EN adds a saturating 16-bit contention
// counter (perf_clear / perf_rdata ports).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  input  logic        perf_clear,
  output logic [15:0] perf_rdata
`endif
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;   // 1: D side held the most recent grant
  logic   d_req;

  assign d_req = bus.d_read | bus.d_write;

  // State and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;          // first tie after reset goes to I
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Next-state, downstream mux and completion steering
  always_comb begin
    state_nxt       = state;
    last_d_nxt      = last_d;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.i_resp      = 1'b0;
    bus.i_rdata     = '0;
    bus.d_resp      = 1'b0;
    bus.d_rdata     = '0;
    unique case (state)
      IDLE: begin
        // mem_resp here is stray and deliberately ignored
        if (bus.i_read && d_req) state_nxt = last_d ? SERVE_I : SERVE_D;
        else if (bus.i_read)     state_nxt = SERVE_I;
        else if (d_req)          state_nxt = SERVE_D;
      end
      SERVE_I: begin
        bus.mem_read    = bus.i_read;
        bus.mem_address = bus.i_address;
        // rst in the same cycle discards the completion
        if (bus.mem_resp && !rst) begin
          bus.i_resp  = 1'b1;
          bus.i_rdata = bus.mem_rdata;
          last_d_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      SERVE_D: begin
        bus.mem_read    = bus.d_read;
        bus.mem_write   = bus.d_write;
        bus.mem_address = bus.d_address;
        bus.mem_wdata   = bus.d_wdata;
        if (bus.mem_resp && !rst) begin
          bus.d_resp  = 1'b1;
          bus.d_rdata = bus.mem_rdata;
          last_d_nxt  = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_PERF_EN
  logic contend;

  // A cycle is contended when one side waits on the other's grant, or both
  // are requesting while IDLE.
  always_comb begin
    contend = 1'b0;
    unique case (state)
      IDLE:    contend = bus.i_read & d_req;
      SERVE_I: contend = d_req;
      SERVE_D: contend = bus.i_read;
      default: contend = 1'b0;
    endcase
  end

  // Saturating contention counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || perf_clear)                   perf_rdata <= '0;
    else if (contend && perf_rdata != 16'hFFFF) perf_rdata <= perf_rdata + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after the rising
// edge and outputs are sampled a further unit later.
// With ARB_PERF_EN defined the contention counter is exercised as well.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef ARB_PERF_EN
  logic        perf_clear = 1'b0;
  logic [15:0] perf_rdata;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ARB_PERF_EN
    ,
    .perf_clear (perf_clear),
    .perf_rdata (perf_rdata)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [LINE_W-1:0] RD_A = {16{8'hA5}};
  localparam logic [LINE_W-1:0] RD_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LINE_W-1:0] WD_D = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    settle();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_mem_read",  bus.mem_read,    0);
    chk("rst_mem_write", bus.mem_write,   0);
    chk("rst_mem_addr",  bus.mem_address, 0);
    chk("rst_i_resp",    bus.i_resp,      0);
    chk("rst_d_resp",    bus.d_resp,      0);

    // 1: lone I read, mem_resp in the third serve cycle
    bus.i_read = 1'b1; bus.i_address = 16'h1230; settle();
    chk("t1_no_strobe_same_cycle", bus.mem_read, 0);
    tick();
    chk("t1_rd_c1",   bus.mem_read,    1);
    chk("t1_addr",    bus.mem_address, 16'h1230);
    chk("t1_iresp_0", bus.i_resp,      0);
    chk("t1_irdata0", bus.i_rdata,     0);
    tick();
    chk("t1_rd_c2", bus.mem_read, 1);
    tick();
    bus.mem_resp = 1'b1; bus.mem_rdata = RD_A; settle();
    chk("t1_rd_c3",   bus.mem_read, 1);
    chk("t1_iresp",   bus.i_resp,   1);
    chk("t1_irdata",  bus.i_rdata,  RD_A);
    chk("t1_dresp",   bus.d_resp,   0);
    chk("t1_drdata",  bus.d_rdata,  0);
    tick();
    idle_inputs(); bus.mem_rdata = RD_A; settle();
    chk("t1_gap_rd",    bus.mem_read, 0);
    chk("t1_gap_iresp", bus.i_resp,   0);
    chk("t1_gap_rdata", bus.i_rdata,  0);
    bus.mem_rdata = '0;

    // 2: i_read and d_write together after reset -> I, gap, then D
    do_reset();
    bus.i_read = 1'b1; bus.i_address = 16'h0440;
    bus.d_write = 1'b1; bus.d_address = 16'h2000; bus.d_wdata = WD_D;
    tick();
    chk("t2_i_first_rd",   bus.mem_read,    1);
    chk("t2_i_first_wr",   bus.mem_write,   0);
    chk("t2_i_first_addr", bus.mem_address, 16'h0440);
    chk("t2_i_wdata0",     bus.mem_wdata,   0);
    bus.mem_resp = 1'b1; bus.mem_rdata = RD_B; settle();
    chk("t2_iresp", bus.i_resp, 1);
    chk("t2_dresp", bus.d_resp, 0);
    tick();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0; settle();
    chk("t2_gap_rd", bus.mem_read,  0);
    chk("t2_gap_wr", bus.mem_write, 0);
    tick();
    chk("t2_d_wr",    bus.mem_write,   1);
    chk("t2_d_rd",    bus.mem_read,    0);
    chk("t2_d_addr",  bus.mem_address, 16'h2000);
    chk("t2_d_wdata", bus.mem_wdata,   WD_D);
    bus.mem_resp = 1'b1; settle();
    chk("t2_dresp_d", bus.d_resp, 1);
    chk("t2_iresp_d", bus.i_resp, 0);
    tick();
    idle_inputs(); settle();

    // 3: both held for 4 transactions -> I, D, I, D
    bus.i_read = 1'b1; bus.i_address = 16'h1111;
    bus.d_read = 1'b1; bus.d_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      logic want_i;
      want_i = (k % 2 == 0);
      tick();
      chk($sformatf("t3_addr_%0d", k), bus.mem_address, want_i ? 16'h1111 : 16'h2222);
      bus.mem_resp = 1'b1; bus.mem_rdata = RD_B; settle();
      chk($sformatf("t3_iresp_%0d", k), bus.i_resp, want_i);
      chk($sformatf("t3_dresp_%0d", k), bus.d_resp, !want_i);
      tick();
      bus.mem_resp = 1'b0; settle();
      chk($sformatf("t3_gap_%0d", k), bus.mem_read, 0);
    end
    idle_inputs(); settle();

    // 4: rst while SERVE_D waits -> strobes drop, late mem_resp ignored
    bus.d_read = 1'b1; bus.d_address = 16'h3330;
    tick();
    chk("t4_serving", bus.mem_read, 1);
    tick();
    rst = 1'b1; bus.d_read = 1'b0;
    tick();
    rst = 1'b0; settle();
    chk("t4_rd_drop", bus.mem_read,  0);
    chk("t4_wr_drop", bus.mem_write, 0);
    bus.mem_resp = 1'b1; bus.mem_rdata = RD_A; settle();
    chk("t4_no_dresp", bus.d_resp,  0);
    chk("t4_no_drd",   bus.d_rdata, 0);

    // 5: mem_resp while IDLE with no requests
    tick();
    chk("t5_no_iresp", bus.i_resp,      0);
    chk("t5_no_dresp", bus.d_resp,      0);
    chk("t5_addr0",    bus.mem_address, 0);
    tick();
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    // still IDLE, and reset restored last_grant=D so a tie goes to I
    bus.i_read = 1'b1; bus.i_address = 16'h0AA0;
    bus.d_read = 1'b1; bus.d_address = 16'h0BB0;
    settle();
    chk("t5_idle_rd", bus.mem_read, 0);
    tick();
    chk("t5_tie_to_i", bus.mem_address, 16'h0AA0);
    bus.mem_resp = 1'b1; settle();
    tick();
    idle_inputs(); settle();

`ifdef ARB_PERF_EN
    // 6: contention counter
    do_reset();
    chk("t6_rst", perf_rdata, 0);
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    tick(10);
    chk("t6_ten", perf_rdata, 10);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0; settle();
    chk("t6_clear_wins", perf_rdata, 0);
    tick(65540);
    chk("t6_saturate", perf_rdata, 16'hFFFF);
    tick(3);
    chk("t6_hold", perf_rdata, 16'hFFFF);
    idle_inputs();
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
